muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the ALU in the execute stage and takes over the work that the ALU decoder flags with hiloen.
- Covers MULT/MULTU/DIV/DIVU (multi-cycle) and MTHI/MTLO (single-cycle).
- Exposes HI/LO continuously for MFHI/MFLO.
- Provides busy/done for hazard-unit stalling and a flush input for pipeline squash.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits (legal range 4..64, even).

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored)
a  in  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO data)
b  in  WIDTH  operand rt (divisor / multiplier)
flush  in  1  abort any in-flight operation
busy  out  1  high while a mul/div is in progress; hazard unit stalls MFHI/MFLO/mul/div on it
done  out  1  one-cycle pulse when HI/LO have just been written by a mul/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
Reset (sync, highest priority)
- hi=0, lo=0, busy=0, done=0; state IDLE; counter 0.
- An operation in progress when reset is applied is discarded.

States: IDLE, RUN.
- IDLE, start=1, flush=0, op=MTHI: hi<=a at that edge. lo, busy, done unchanged.
- IDLE, start=1, flush=0, op=MTLO: lo<=a at that edge. hi, busy, done unchanged.
- IDLE, start=1, flush=0, op in {MULT, MULTU, DIV, DIVU}:
  - latch op, sign flags and operand magnitudes (|a|, |b| for signed ops; raw values for unsigned);
  - counter<=WIDTH; go to RUN; busy=1 from the next cycle.
- IDLE, reserved op: no effect.
- RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements.
  - On the edge where counter reaches 0: hi/lo written, state<=IDLE, busy<=0, done<=1 for exactly one cycle.
- Latency: start accepted at edge E0; result visible and done=1 after edge E0+WIDTH. busy is high for WIDTH cycles.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit must hold them.
- start may be accepted in the same cycle that done=1 (busy already 0). Back-to-back issue is legal.
- flush=1: state<=IDLE, busy<=0, done<=0; hi/lo unchanged. flush beats start in the same cycle. flush in IDLE also cancels an MTHI/MTLO presented that cycle.
- flush on the completion edge wins: no write, no done.

Arithmetic
- MULT/MULTU: {hi,lo} = 2*WIDTH-bit product, signed or unsigned. For signed, the magnitude product is negated when sign(a)!=sign(b).
- DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder.
  - Remainder takes the sign of the dividend; quotient sign = sign(a) xor sign(b).
- Signed overflow, most-negative / -1: lo = most-negative value, hi = 0.
- Divide by zero, signed or unsigned: lo = all ones, hi = a unmodified. Special-cased at completion; same latency.
- Sign fix-up is combinational at writeback; it adds no cycles.

Test Plan:
(WIDTH=32 throughout.)
- MULT a=FFFFFFFD (-3), b=00000005 -> after 32 cycles, done pulse, hi=FFFFFFFF, lo=FFFFFFF1. busy high exactly 32 cycles.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then immediately DIV a=FFFFFFF9 (-7), b=2 issued in the done cycle -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=7, b=0 -> lo=FFFFFFFF, hi=00000007. Then DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- MTHI a=12345678 then MTLO a=9ABCDEF0 on consecutive cycles -> hi=12345678, lo=9ABCDEF0 one edge each, busy stays 0, done stays 0.
- Ignored/cancelled requests:
  - MULT 10*10 started; MTLO a=1 presented at cycle 5 -> ignored.
  - flush at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values.
  - flush and start together -> nothing accepted.
- Reset asserted at cycle 20 of a DIVU -> hi=lo=0, busy=0, done=0 after that edge. No done later.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per cycle; sign fix-up happens at writeback.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_is_div, r_neg_q, r_neg_r, r_bzero;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q, r_d;

  logic             w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum, w_add, w_shift, w_diff, w_p_nxt;
  logic [WIDTH-1:0] w_q_nxt, w_rem_mag, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // r_p is the partial product (mul) or partial remainder (div); r_q holds multiplier or dividend/quotient.
  always_comb begin
    w_sum     = r_p + {1'b0, r_d};
    w_add     = r_q[0] ? w_sum : r_p;
    w_shift   = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_d};
    w_p_nxt   = '0;
    w_q_nxt   = '0;
    if (r_is_div) begin
      if (!w_diff[WIDTH]) begin
        w_p_nxt = w_diff;
        w_q_nxt = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_p_nxt = w_shift;
        w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_p_nxt = {1'b0, w_add[WIDTH:1]};
      w_q_nxt = {w_add[0], r_q[WIDTH-1:1]};
    end

    w_prod    = {w_p_nxt[WIDTH-1:0], w_q_nxt};
    w_rem_mag = w_p_nxt[WIDTH-1:0];
    w_res_hi  = '0;
    w_res_lo  = '0;
    if (!r_is_div) begin
      if (r_neg_q) w_prod = -w_prod;
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else if (r_bzero) begin
      w_res_hi = r_a_raw;
      w_res_lo = '1;
    end else begin
      w_res_hi = r_neg_r ? -w_rem_mag : w_rem_mag;
      w_res_lo = r_neg_q ? -w_q_nxt : w_q_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_a_raw  <= '0;
      r_p      <= '0;
      r_q      <= '0;
      r_d      <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              case (op)
                3'b000, 3'b001, 3'b010, 3'b011: begin
                  r_is_div <= op[1];
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_bzero  <= (b == '0);
                  r_a_raw  <= a;
                  r_p      <= '0;
                  r_q      <= op[1] ? w_a_mag : w_b_mag;
                  r_d      <= op[1] ? w_b_mag : w_a_mag;
                  r_cnt    <= CW'(WIDTH);
                  r_state  <= S_RUN;
                  r_busy   <= 1'b1;
                end
                3'b100:  r_hi <= a;
                3'b101:  r_lo <= a;
                default: ;
              endcase
            end
          end
          S_RUN: begin
            r_p   <= w_p_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
              r_hi    <= w_res_hi;
              r_lo    <= w_res_lo;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
